// File: rtl/rstseq_pkg.sv
// ============================================================================
// Module      : rstseq_pkg
// Description : Shared constants for the reset sequencer: FSM state codes and
//               the RST_CAUSE encodings reported to software.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rstseq_pkg;

    // Sequencer FSM states
    localparam logic [2:0] ST_ASSERT = 3'd0;  // both domains held in reset
    localparam logic [2:0] ST_REL_P  = 3'd1;  // peripheral domain released
    localparam logic [2:0] ST_REL_C  = 3'd2;  // core released, awaiting CORE_RDY
    localparam logic [2:0] ST_RUN    = 3'd3;  // normal operation
    localparam logic [2:0] ST_LOCK   = 3'd4;  // watchdog lockout (optional)

    // Cause of the most recent reset sequence
    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_WD  = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_TMO = 2'b11;

endpackage : rstseq_pkg

`default_nettype wire

// File: rtl/reset_sequencer_if.sv
// ============================================================================
// Module      : reset_sequencer_if
// Description : Request/status bundle between the reset sequencer and the
//               rest of the SoC.
// Ports       : master modport - drives RSTIN, SW_RST, CORE_RDY; observes
//                                 RST_PERIPH, RST_CORE, RST_CAUSE, WDCNT,
//                                 LOCKOUT
//               slave modport  - the sequencer side (directions reversed)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reset_sequencer_if;

    logic       RSTIN;       // watchdog reset request (level)
    logic       SW_RST;      // software reset request (level)
    logic       CORE_RDY;    // core boot complete
    logic       RST_PERIPH;  // peripheral-domain reset, active-high
    logic       RST_CORE;    // core-domain reset, active-high
    logic [1:0] RST_CAUSE;   // cause of the last sequence
    logic [7:0] WDCNT;       // saturating watchdog reset count
    logic       LOCKOUT;     // high while locked out

    modport master (
        output RSTIN, SW_RST, CORE_RDY,
        input  RST_PERIPH, RST_CORE, RST_CAUSE, WDCNT, LOCKOUT
    );

    modport slave (
        input  RSTIN, SW_RST, CORE_RDY,
        output RST_PERIPH, RST_CORE, RST_CAUSE, WDCNT, LOCKOUT
    );

endinterface : reset_sequencer_if

`default_nettype wire

// File: rtl/seq_timer.sv
// ============================================================================
// Module      : seq_timer
// Description : Loadable up-counter with terminal-count flag. Load clears the
//               count to zero; the counter then advances each enabled cycle
//               and parks at the terminal value, so o_tc stays high until the
//               next load.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               i_load     - clear count to zero (priority over enable)
//               i_en       - count enable
//               i_term     - terminal value (phase length minus one)
//               o_tc       - count equals i_term
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_term,
    output logic                  o_tc
);

    logic [WIDTH-1:0] r_count;

    assign o_tc = (r_count == i_term);

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : seq_timer

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module      : reset_sequencer
// Description : Power-on / watchdog / software reset sequencer. Holds both
//               domains in reset, releases the peripheral domain, then the
//               core, and waits for the core to report ready. Watchdog and
//               software requests are edge-detected and restart the sequence.
// Macro       : RSTSEQ_LOCKOUT_EN - enables the consecutive-watchdog lockout
//               (LOCK state, CONS counter and CLR_CYC run timer).
// Ports       : CLK, RST      - clock, synchronous active-high power-on reset
//               rs (slave)    - RSTIN, SW_RST, CORE_RDY in;
//                               RST_PERIPH, RST_CORE, RST_CAUSE, WDCNT,
//                               LOCKOUT out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 8,
    parameter int RDY_TMO  = 255,
    parameter int LOCK_LMT = 4,
    parameter int CLR_CYC  = 1024
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    reset_sequencer_if.slave rs
);

    // Phase timer is shared by ASSERT, REL_P and REL_C; size it for the longest.
    localparam int c_PH_MAX = (HOLD_CYC > GAP_CYC)
                            ? ((HOLD_CYC > RDY_TMO) ? HOLD_CYC : RDY_TMO)
                            : ((GAP_CYC  > RDY_TMO) ? GAP_CYC  : RDY_TMO);
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);

    localparam logic [c_PH_W-1:0] c_HOLD_TERM = c_PH_W'(HOLD_CYC - 1);
    localparam logic [c_PH_W-1:0] c_GAP_TERM  = c_PH_W'(GAP_CYC - 1);
    localparam logic [c_PH_W-1:0] c_TMO_TERM  = c_PH_W'(RDY_TMO - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause_nxt;
    logic [7:0]        r_wdcnt;
    logic              r_rstin_q;
    logic              r_swrst_q;
    logic              w_wd_req;
    logic              w_sw_req;
    logic              w_restart;
    logic              w_ph_load;
    logic              w_ph_tc;
    logic              w_lock_hit;
    logic [c_PH_W-1:0] w_ph_term;

    // Edge registers track the raw level every cycle, so a request held high
    // through a whole sequence fires once only.
    assign w_wd_req  = rs.RSTIN  && !r_rstin_q && (r_state != ST_LOCK);
    assign w_sw_req  = rs.SW_RST && !r_swrst_q && (r_state != ST_LOCK);
    assign w_restart = w_wd_req || w_sw_req;

    // Reload on every state entry, including ASSERT re-entered from ASSERT.
    assign w_ph_load = w_restart || (w_state_nxt != r_state);

    always_comb begin
        w_ph_term = '1;
        case (r_state)
            ST_ASSERT: w_ph_term = c_HOLD_TERM;
            ST_REL_P:  w_ph_term = c_GAP_TERM;
            ST_REL_C:  w_ph_term = c_TMO_TERM;
            default:   w_ph_term = '1;
        endcase
    end

    seq_timer #(
        .WIDTH (c_PH_W)
    ) u_phase_timer (
        .clk    (CLK),
        .rst    (RST),
        .i_load (w_ph_load),
        .i_en   (1'b1),
        .i_term (w_ph_term),
        .o_tc   (w_ph_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        if (w_restart) begin
            // Watchdog has priority over a coincident software request.
            w_state_nxt = ST_ASSERT;
            w_cause_nxt = w_wd_req ? CAUSE_WD : CAUSE_SW;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    if (w_ph_tc) begin
                        w_state_nxt = w_lock_hit ? ST_LOCK : ST_REL_P;
                    end
                end
                ST_REL_P: begin
                    if (w_ph_tc) begin
                        w_state_nxt = ST_REL_C;
                    end
                end
                ST_REL_C: begin
                    if (rs.CORE_RDY) begin
                        w_state_nxt = ST_RUN;
                    end else if (w_ph_tc) begin
                        w_state_nxt = ST_ASSERT;
                        w_cause_nxt = CAUSE_TMO;
                    end
                end
                ST_RUN:  w_state_nxt = ST_RUN;
                ST_LOCK: w_state_nxt = ST_LOCK;
                default: w_state_nxt = ST_ASSERT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_ASSERT;
            r_cause   <= CAUSE_POR;
            r_wdcnt   <= 8'd0;
            r_rstin_q <= 1'b0;
            r_swrst_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            r_rstin_q <= rs.RSTIN;
            r_swrst_q <= rs.SW_RST;
            if (w_wd_req && (r_wdcnt != 8'hFF)) begin
                r_wdcnt <= r_wdcnt + 8'd1;
            end
        end
    end

`ifdef RSTSEQ_LOCKOUT_EN
    localparam int                c_RUN_W    = $clog2(CLR_CYC + 1);
    localparam logic [c_RUN_W-1:0] c_CLR_TERM = c_RUN_W'(CLR_CYC - 1);

    logic [2:0] r_cons;
    logic [2:0] w_cons_base;
    logic       w_run_tc;
    logic       w_cons_clr;

    // Counts consecutive RUN cycles; any exit from RUN restarts it.
    seq_timer #(
        .WIDTH (c_RUN_W)
    ) u_run_timer (
        .clk    (CLK),
        .rst    (RST),
        .i_load (r_state != ST_RUN),
        .i_en   (1'b1),
        .i_term (c_CLR_TERM),
        .o_tc   (w_run_tc)
    );

    assign w_cons_clr  = (r_state == ST_RUN) && w_run_tc;
    assign w_cons_base = w_cons_clr ? 3'd0 : r_cons;

    // CONS only changes outside RUN's clear window by watchdog edges, so
    // checking it at the end of the hold phase equals checking it on entry.
    assign w_lock_hit  = (32'(r_cons) >= 32'(LOCK_LMT));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cons <= 3'd0;
        end else if (w_wd_req && (w_cons_base != 3'd7)) begin
            r_cons <= w_cons_base + 3'd1;
        end else begin
            r_cons <= w_cons_base;
        end
    end

    assign rs.LOCKOUT = (r_state == ST_LOCK);
`else
    logic w_unused_cfg;

    // Lockout configuration has no effect in this build.
    assign w_unused_cfg = ^{32'(LOCK_LMT), 32'(CLR_CYC)};
    assign w_lock_hit   = 1'b0;
    assign rs.LOCKOUT   = 1'b0;
`endif

    assign rs.RST_PERIPH = (r_state == ST_ASSERT) || (r_state == ST_LOCK);
    assign rs.RST_CORE   = (r_state != ST_REL_C) && (r_state != ST_RUN);
    assign rs.RST_CAUSE  = r_cause;
    assign rs.WDCNT      = r_wdcnt;

endmodule : reset_sequencer

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Self-checking bench for reset_sequencer (default parameters).
//               Table of {inputs, wait, expected outputs} records followed by
//               hand-written multi-cycle sequences; expectations are queued
//               when stimulus is applied and popped when outputs are sampled.
// Macro       : RSTSEQ_LOCKOUT_EN - also runs the lockout sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reset_sequencer;

    logic CLK = 1'b0;
    logic RST;

    reset_sequencer_if rs ();

    reset_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .rs  (rs)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int unsigned cyc;
        logic        rstin;
        logic        sw;
        logic        rdy;
        logic        p;
        logic        c;
        logic [1:0]  ca;
        logic [7:0]  wd;
        logic        lk;
    } vec_t;

    typedef struct {
        string       name;
        logic [12:0] exp;
    } sb_t;

    vec_t vt[$];
    sb_t  sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input string nm, input int unsigned cyc,
                       input logic rstin, input logic sw, input logic rdy,
                       input logic p, input logic c, input logic [1:0] ca,
                       input logic [7:0] wd, input logic lk);
        vec_t v;
        v.name = nm; v.cyc = cyc; v.rstin = rstin; v.sw = sw; v.rdy = rdy;
        v.p = p; v.c = c; v.ca = ca; v.wd = wd; v.lk = lk;
        vt.push_back(v);
    endtask

    task automatic push_exp(input string nm, input logic p, input logic c,
                            input logic [1:0] ca, input logic [7:0] wd,
                            input logic lk);
        sb_t e;
        e.name = nm;
        e.exp  = {p, c, ca, wd, lk};
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        sb_t         e;
        logic [12:0] act;
        act = {rs.RST_PERIPH, rs.RST_CORE, rs.RST_CAUSE, rs.WDCNT, rs.LOCKOUT};
        n_cmp++;
        if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got %013b, no expectation queued", act);
        end else begin
            e = sbq.pop_front();
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got periph=%0b core=%0b cause=%02b wdcnt=%0d lockout=%0b, need periph=%0b core=%0b cause=%02b wdcnt=%0d lockout=%0b",
                         e.name, act[12], act[11], act[10:9], act[8:1], act[0],
                         e.exp[12], e.exp[11], e.exp[10:9], e.exp[8:1], e.exp[0]);
            end
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Queue the expectation, advance n cycles, then compare.
    task automatic expect_after(input string nm, input int unsigned n,
                                input logic p, input logic c,
                                input logic [1:0] ca, input logic [7:0] wd,
                                input logic lk);
        push_exp(nm, p, c, ca, wd, lk);
        step(n);
        pop_check();
    endtask

    task automatic do_reset(input string nm);
        RST = 1'b1;
        rs.RSTIN = 1'b0;
        rs.SW_RST = 1'b0;
        push_exp(nm, 1'b1, 1'b1, 2'b00, 8'd0, 1'b0);
        step(2);
        RST = 1'b0;
        pop_check();
    endtask

    // Single watchdog pulse from RUN; sequence completes back to RUN.
    task automatic wd_pulse(input string nm, input logic [7:0] wd_exp);
        rs.RSTIN = 1'b1;
        expect_after({nm, "_assert"}, 1, 1'b1, 1'b1, 2'b01, wd_exp, 1'b0);
        rs.RSTIN = 1'b0;
        expect_after({nm, "_run"}, 29, 1'b0, 1'b0, 2'b01, wd_exp, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, need finish before 2 ms");
        $fatal(1);
    end

    initial begin
        RST         = 1'b1;
        rs.RSTIN    = 1'b0;
        rs.SW_RST   = 1'b0;
        rs.CORE_RDY = 1'b1;

        //   name            cyc  wdin sw rdy  P  C  cause wd  lk
        add("por_hold",      15, 0, 0, 1, 1, 1, 2'b00, 8'd0, 0);
        add("por_rel_p",      1, 0, 0, 1, 0, 1, 2'b00, 8'd0, 0);
        add("por_gap",        7, 0, 0, 1, 0, 1, 2'b00, 8'd0, 0);
        add("por_rel_c",      1, 0, 0, 1, 0, 0, 2'b00, 8'd0, 0);
        add("por_run",        5, 0, 0, 1, 0, 0, 2'b00, 8'd0, 0);
        add("wd_edge",        1, 1, 0, 1, 1, 1, 2'b01, 8'd1, 0);
        add("wd_hold",       15, 1, 0, 1, 1, 1, 2'b01, 8'd1, 0);
        add("wd_rel_p",       1, 1, 0, 1, 0, 1, 2'b01, 8'd1, 0);
        add("wd_rel_c",       8, 1, 0, 1, 0, 0, 2'b01, 8'd1, 0);
        add("wd_level_once", 30, 1, 0, 1, 0, 0, 2'b01, 8'd1, 0);
        add("wd_low",         3, 0, 0, 1, 0, 0, 2'b01, 8'd1, 0);
        add("both_edge",      1, 1, 1, 1, 1, 1, 2'b01, 8'd2, 0);
        add("both_done",     24, 0, 0, 1, 0, 0, 2'b01, 8'd2, 0);
        add("sw_edge",        1, 0, 1, 1, 1, 1, 2'b10, 8'd2, 0);
        add("sw_mid",        10, 0, 0, 1, 1, 1, 2'b10, 8'd2, 0);
        add("sw_restart",     1, 0, 1, 1, 1, 1, 2'b10, 8'd2, 0);
        add("restart_hold",  15, 0, 0, 1, 1, 1, 2'b10, 8'd2, 0);
        add("restart_rel_p",  1, 0, 0, 1, 0, 1, 2'b10, 8'd2, 0);
        add("wd_in_rel_p",    1, 1, 0, 1, 1, 1, 2'b01, 8'd3, 0);
        add("wd_relp_hold",  15, 0, 0, 1, 1, 1, 2'b01, 8'd3, 0);
        add("wd_relp_rel_p",  1, 0, 0, 1, 0, 1, 2'b01, 8'd3, 0);
        add("wd_relp_rel_c",  8, 0, 0, 1, 0, 0, 2'b01, 8'd3, 0);
        add("tmo_sw",         1, 0, 1, 0, 1, 1, 2'b10, 8'd3, 0);
        add("tmo_hold",      15, 0, 0, 0, 1, 1, 2'b10, 8'd3, 0);
        add("tmo_rel_p",      1, 0, 0, 0, 0, 1, 2'b10, 8'd3, 0);
        add("tmo_rel_c",      8, 0, 0, 0, 0, 0, 2'b10, 8'd3, 0);
        add("tmo_wait",     254, 0, 0, 0, 0, 0, 2'b10, 8'd3, 0);
        add("tmo_fire",       1, 0, 0, 0, 1, 1, 2'b11, 8'd3, 0);
        add("tmo_recover",   24, 0, 0, 1, 0, 0, 2'b11, 8'd3, 0);

        do_reset("reset_state");

        for (int i = 0; i < vt.size(); i++) begin
            rs.RSTIN    = vt[i].rstin;
            rs.SW_RST   = vt[i].sw;
            rs.CORE_RDY = vt[i].rdy;
            expect_after(vt[i].name, vt[i].cyc, vt[i].p, vt[i].c, vt[i].ca,
                         vt[i].wd, vt[i].lk);
        end

        // Two pulses, a long RUN stretch to clear CONS, then three more.
        do_reset("clr_reset");
        rs.CORE_RDY = 1'b1;
        expect_after("clr_to_run", 25, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0);
        wd_pulse("clr_p1", 8'd1);
        wd_pulse("clr_p2", 8'd2);
        expect_after("clr_long_run", 1030, 1'b0, 1'b0, 2'b01, 8'd2, 1'b0);
        wd_pulse("clr_p3", 8'd3);
        wd_pulse("clr_p4", 8'd4);
        wd_pulse("clr_p5", 8'd5);

`ifdef RSTSEQ_LOCKOUT_EN
        // Four pulses close together lock the sequencer out.
        do_reset("lock_reset");
        expect_after("lock_to_run", 25, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0);
        wd_pulse("lock_p1", 8'd1);
        wd_pulse("lock_p2", 8'd2);
        wd_pulse("lock_p3", 8'd3);
        rs.RSTIN = 1'b1;
        expect_after("lock_p4_assert", 1, 1'b1, 1'b1, 2'b01, 8'd4, 1'b0);
        rs.RSTIN = 1'b0;
        expect_after("lock_p4_hold", 15, 1'b1, 1'b1, 2'b01, 8'd4, 1'b0);
        expect_after("lock_entered", 1, 1'b1, 1'b1, 2'b01, 8'd4, 1'b1);
        rs.RSTIN = 1'b1;
        rs.SW_RST = 1'b1;
        expect_after("lock_p5_ignored", 2, 1'b1, 1'b1, 2'b01, 8'd4, 1'b1);
        rs.RSTIN = 1'b0;
        rs.SW_RST = 1'b0;
        expect_after("lock_stays", 40, 1'b1, 1'b1, 2'b01, 8'd4, 1'b1);
`else
        // Back-to-back watchdog edges drive WDCNT into saturation.
        for (int k = 0; k < 252; k++) begin
            rs.RSTIN = 1'b1;
            step(1);
            rs.RSTIN = 1'b0;
            step(1);
        end
        expect_after("wdcnt_saturated", 25, 1'b0, 1'b0, 2'b01, 8'd255, 1'b0);
`endif

        do_reset("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_reset_sequencer

`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYC, default 16: cycles both domain resets stay asserted in ASSERT.
REQ-002 Parameter GAP_CYC, default 8: cycles between peripheral release and core release.
REQ-003 Parameter RDY_TMO, default 255: maximum cycles to wait for CORE_RDY after core release.
REQ-004 Parameter LOCK_LMT, default 4: consecutive watchdog resets that cause lockout.
REQ-005 Parameter CLR_CYC, default 1024: cycles in RUN that clear the consecutive-failure count.
REQ-006 Port CLK, input, 1: single clock; every flop samples on the rising edge.
REQ-007 Port RST, input, 1: synchronous active-high reset (power-on reset).
REQ-008 Port RSTIN, input, 1: watchdog reset request from the watchdog RSTOUT; level, active-high.
REQ-009 Port SW_RST, input, 1: software reset request; level, active-high.
REQ-010 Port CORE_RDY, input, 1: core reports boot complete.
REQ-011 Port RST_PERIPH, output, 1: peripheral-domain reset; active-high.
REQ-012 Port RST_CORE, output, 1: core-domain reset; active-high.
REQ-013 Port RST_CAUSE, output, 2: cause of the last sequence; 00 POR, 01 WD, 10 SW, 11 RDY timeout.
REQ-014 Port WDCNT, output, 8: total watchdog resets; saturates at 255.
REQ-015 Port LOCKOUT, output, 1: high while in LOCK.

Function
REQ-016 States SHALL be ASSERT, REL_P, REL_C, RUN and LOCK.
REQ-017 ASSERT: RST_PERIPH=1, RST_CORE=1; after HOLD_CYC cycles go to REL_P.
REQ-018 REL_P: RST_PERIPH=0, RST_CORE=1; after GAP_CYC cycles go to REL_C.
REQ-019 REL_C: both resets 0; CORE_RDY=1 goes to RUN next cycle.
REQ-020 REL_C timeout: after RDY_TMO cycles with CORE_RDY=0, set RST_CAUSE=11 and go to ASSERT.
REQ-021 In any state other than LOCK, a rising edge of RSTIN (registered, edge-detected) SHALL enter ASSERT next cycle with RST_CAUSE=01.
REQ-022 A RSTIN edge SHALL also increment WDCNT (saturating) and the internal consecutive count CONS (3-bit, saturating at 7).
REQ-023 In any state other than LOCK, a SW_RST rising edge SHALL enter ASSERT with RST_CAUSE=10; it does not change CONS.
REQ-024 Simultaneous RSTIN and SW_RST edges: watchdog wins; cause 01 and the counters increment.
REQ-025 A request arriving mid-sequence SHALL restart ASSERT with the full HOLD_CYC count.
REQ-026 CONS SHALL clear after CLR_CYC consecutive cycles in RUN.
REQ-027 Edge-detect registers SHALL hold the sampled input level, so a level held high across sequences triggers only once.
REQ-028 The phase timer SHALL reload to 0 on every state entry; terminal count is N-1, so a phase of N lasts exactly N cycles.

Reset
REQ-029 On RST: state ASSERT, phase timer 0, RST_PERIPH=1, RST_CORE=1, RST_CAUSE=00, WDCNT=0, CONS=0, LOCKOUT=0, edge-detect registers 0.
REQ-030 RST SHALL override all inputs and states, including LOCK.

Configuration
REQ-031 Macro RSTSEQ_LOCKOUT_EN defined: when CONS reaches LOCK_LMT on entry to ASSERT, finish the HOLD_CYC phase, then go to LOCK.
REQ-032 In LOCK: both resets held at 1, LOCKOUT=1, all requests ignored; only RST exits LOCK.
REQ-033 Macro RSTSEQ_LOCKOUT_EN undefined: LOCK state, CONS logic and CLR_CYC logic are absent; LOCKOUT is tied to 0.

Structure
REQ-034 Package rstseq_pkg SHALL hold the state enumeration and the RST_CAUSE codes (CAUSE_POR, CAUSE_WD, CAUSE_SW, CAUSE_TMO).
REQ-035 Sub-module seq_timer: a loadable up-counter with a terminal-count flag.
REQ-036 seq_timer SHALL be instantiated twice: once for the phase timer and once for the CLR_CYC run timer.

Verification
REQ-037 Scenario RST pulse then idle inputs, CORE_RDY=1 at REL_C: RST_PERIPH falls 16 cycles after RST deassert; RST_CORE falls 8 cycles later; RUN follows; RST_CAUSE=00.
REQ-038 Scenario RSTIN held high 50 cycles during RUN: exactly one sequence runs; WDCNT=1; RST_CAUSE=01.
REQ-039 Scenario RSTIN and SW_RST rising in the same cycle: RST_CAUSE=01; WDCNT increments by 1.
REQ-040 Scenario CORE_RDY held 0: ASSERT re-entered 255 cycles after core release; RST_CAUSE=11.
REQ-041 Scenario, LOCKOUT_EN defined: 4 RSTIN pulses with fewer than 1024 RUN cycles between them give LOCKOUT=1 and both resets 1; a 5th pulse is ignored and WDCNT stays 4; RST clears all.
REQ-042 Scenario: 2 RSTIN pulses, then 1024 cycles in RUN, then 3 more pulses: no lockout.
